id_stage: RTL

- Instruction decode/issue stage for the RV64I core, on the producing side of the execute-stage ALU interface.
- Accepts a fetched instruction and its PC from fetch over a valid/ready handshake, and reads rs1/rs2 from the register file.
- Builds the 11-bit op_ir word ({instr[30], funct3, opcode}), generates the immediate, and selects operands a/b.
- Registers the result into a single ID/EX pipeline register, with load-use interlock and flush.

---
 rtl/rv6_pkg.sv | 54 +++++
 rtl/imm_gen.sv | 27 ++
 rtl/id_stage.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/rv6_pkg.sv
// Shared decode definitions for the RV64I decode/issue stage: opcodes,
// op_ir field layout, immediate formats and operand-select encodings.
package rv6_pkg;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  // op_ir layout: [6:0] opcode, [9:7] funct3, [10] instr[30]
  localparam int OPIR_OPC_LSB = 0;
  localparam int OPIR_OPC_MSB = 6;
  localparam int OPIR_F3_LSB  = 7;
  localparam int OPIR_F3_MSB  = 9;
  localparam int OPIR_ALT     = 10;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_type_e;

  typedef enum logic [1:0] {
    A_ZERO,
    A_RS1,
    A_PC
  } a_sel_e;

  typedef enum logic [2:0] {
    B_ZERO,
    B_RS2,
    B_IMM,
    B_SHAMT,
    B_FOUR
  } b_sel_e;

  function automatic logic [10:0] make_op_ir(input logic [31:0] instr);
    logic [10:0] w;
    w = '0;
    w[OPIR_OPC_MSB:OPIR_OPC_LSB] = instr[6:0];
    w[OPIR_F3_MSB:OPIR_F3_LSB]   = instr[14:12];
    w[OPIR_ALT]                  = instr[30];
    return w;
  endfunction

endpackage

// File: rtl/imm_gen.sv
// Combinational immediate generator; every format is sign-extended to XLEN.
module imm_gen
  import rv6_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic [31:0]     instr,
  input  logic [2:0]      imm_sel,
  output logic [XLEN-1:0] imm
);

  // Select and sign-extend the immediate for the requested format.
  always_comb begin
    imm = '0;
    case (imm_sel)
      IMM_I: imm = {{(XLEN-12){instr[31]}}, instr[31:20]};
      IMM_S: imm = {{(XLEN-12){instr[31]}}, instr[31:25], instr[11:7]};
      IMM_B: imm = {{(XLEN-13){instr[31]}}, instr[31], instr[7], instr[30:25],
                    instr[11:8], 1'b0};
      IMM_U: imm = {{(XLEN-32){instr[31]}}, instr[31:12], 12'b0};
      IMM_J: imm = {{(XLEN-21){instr[31]}}, instr[31], instr[19:12], instr[20],
                    instr[30:21], 1'b0};
      default: imm = '0;
    endcase
  end

endmodule

// File: rtl/id_stage.sv
// RV64I decode/issue stage: decodes the fetched instruction, reads operands,
// and registers the op into a single ID/EX register with load-use interlock.
module id_stage
  import rv6_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int ILEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            if_valid,
  output logic            if_ready,
  input  logic [ILEN-1:0] if_instr,
  input  logic [XLEN-1:0] if_pc,
  output logic [4:0]      rs1_addr,
  output logic [4:0]      rs2_addr,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] rs2_data,
  input  logic            ld_pending,
  input  logic [4:0]      ld_rd,
  input  logic            flush,
  output logic            ex_valid,
  input  logic            ex_ready,
  output logic [10:0]     ex_op_ir,
  output logic [XLEN-1:0] ex_a,
  output logic [XLEN-1:0] ex_b,
  output logic [XLEN-1:0] ex_rs2,
  output logic [XLEN-1:0] ex_imm,
  output logic [XLEN-1:0] ex_pc,
  output logic [4:0]      ex_rd,
  output logic            ex_illegal
);

  logic [6:0]      opc;
  logic [2:0]      f3;
  logic            use_rs1;
  logic            use_rs2;
  logic            has_rd;
  logic            illegal;
  imm_type_e       imm_sel;
  a_sel_e          a_sel;
  b_sel_e          b_sel;
  logic [XLEN-1:0] imm_d;
  logic [XLEN-1:0] a_d;
  logic [XLEN-1:0] b_d;
  logic            stall;
  logic            load;

  assign opc      = if_instr[6:0];
  assign f3       = if_instr[14:12];
  assign rs1_addr = if_instr[19:15];
  assign rs2_addr = if_instr[24:20];

  // Opcode decode: source usage, destination presence, immediate and operand selects.
  always_comb begin
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    has_rd  = 1'b1;
    illegal = 1'b0;
    imm_sel = IMM_NONE;
    a_sel   = A_ZERO;
    b_sel   = B_ZERO;
    case (opc)
      OPC_OP: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1;
        a_sel = A_RS1; b_sel = B_RS2;
      end
      OPC_OP_IMM: begin
        use_rs1 = 1'b1; imm_sel = IMM_I; a_sel = A_RS1;
        b_sel = (f3 == 3'b001 || f3 == 3'b101) ? B_SHAMT : B_IMM;
      end
      OPC_LOAD: begin
        use_rs1 = 1'b1; imm_sel = IMM_I; a_sel = A_RS1; b_sel = B_IMM;
      end
      OPC_STORE: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1; has_rd = 1'b0;
        imm_sel = IMM_S; a_sel = A_RS1; b_sel = B_IMM;
      end
      OPC_LUI: begin
        imm_sel = IMM_U; a_sel = A_ZERO; b_sel = B_IMM;
      end
      OPC_AUIPC: begin
        imm_sel = IMM_U; a_sel = A_PC; b_sel = B_IMM;
      end
      OPC_JAL: begin
        imm_sel = IMM_J; a_sel = A_PC; b_sel = B_FOUR;
      end
      OPC_JALR: begin
        use_rs1 = 1'b1; imm_sel = IMM_I; a_sel = A_PC; b_sel = B_FOUR;
      end
      OPC_BRANCH: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1; has_rd = 1'b0;
        imm_sel = IMM_B; a_sel = A_PC; b_sel = B_IMM;
      end
      default: begin
        illegal = 1'b1; has_rd = 1'b0;
      end
    endcase
  end

  imm_gen #(.XLEN(XLEN)) u_imm_gen (
    .instr  (if_instr),
    .imm_sel(imm_sel),
    .imm    (imm_d)
  );

  // Operand muxes feeding the ID/EX register.
  always_comb begin
    a_d = '0;
    b_d = '0;
    case (a_sel)
      A_RS1:   a_d = rs1_data;
      A_PC:    a_d = if_pc;
      default: a_d = '0;
    endcase
    case (b_sel)
      B_RS2:   b_d = rs2_data;
      B_IMM:   b_d = imm_d;
      B_SHAMT: b_d = {{(XLEN-6){1'b0}}, if_instr[25:20]};
      B_FOUR:  b_d = XLEN'(4);
      default: b_d = '0;
    endcase
  end

  // x0 is never a load destination worth waiting on, so ld_rd==0 never stalls.
  assign stall = ld_pending && (ld_rd != 5'd0) &&
                 ((use_rs1 && (ld_rd == rs1_addr)) || (use_rs2 && (ld_rd == rs2_addr)));
  assign if_ready = (!ex_valid || ex_ready) && !stall && !flush;
  assign load     = if_valid && if_ready;

  // ID/EX register: reset, then flush kill, then load, then drain to a bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid   <= 1'b0;
      ex_op_ir   <= '0;
      ex_a       <= '0;
      ex_b       <= '0;
      ex_rs2     <= '0;
      ex_imm     <= '0;
      ex_pc      <= '0;
      ex_rd      <= '0;
      ex_illegal <= 1'b0;
    end else if (flush) begin
      ex_valid <= 1'b0;
    end else if (load) begin
      ex_valid   <= 1'b1;
      ex_op_ir   <= make_op_ir(if_instr);
      ex_a       <= a_d;
      ex_b       <= b_d;
      ex_rs2     <= rs2_data;
      ex_imm     <= imm_d;
      ex_pc      <= if_pc;
      ex_rd      <= has_rd ? if_instr[11:7] : 5'd0;
      ex_illegal <= illegal;
    end else if (ex_ready) begin
      ex_valid <= 1'b0;
    end
  end

endmodule
